// File: rtl/vr_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : vr_fifo_param
// Purpose  : Parametrised valid/ready synchronous FIFO with fill level, flags,
//            flush and high-water mark. Optional bypass: VR_FIFO_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vr_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       put_valid,
  output logic                       put_ready,
  input  logic [WIDTH-1:0]           put_data,
  output logic                       get_valid,
  input  logic                       get_ready,
  output logic [WIDTH-1:0]           get_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] max_level
);

  localparam int c_aw    = $clog2(DEPTH);
  localparam int c_ptr_w = c_aw + 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_af = c_cnt_w'(AF_THRESH);
  localparam logic [c_cnt_w-1:0] c_ae = c_cnt_w'(AE_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_err_depth
    $error("vr_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH > DEPTH) begin : g_err_af
    $error("vr_fifo_param: AF_THRESH must not exceed DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_err_ae
    $error("vr_fifo_param: AE_THRESH must be below DEPTH");
  end

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic [c_cnt_w-1:0] max_q, max_d;

  logic w_full, w_empty, w_pass, w_wr_en, w_rd_en;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                   (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);

  assign put_ready = !w_full && !reset;

`ifdef VR_FIFO_BYPASS_EN
  // Empty FIFO presents the incoming word directly; a same-cycle get consumes it unstored.
  assign get_valid = !reset && (!w_empty || put_valid);
  assign get_data  = w_empty ? put_data : mem_q[rd_ptr_q[c_aw-1:0]];
  assign w_pass    = w_empty && put_valid && get_ready && !reset;
`else
  assign get_valid = !reset && !w_empty;
  assign get_data  = mem_q[rd_ptr_q[c_aw-1:0]];
  assign w_pass    = 1'b0;
`endif

  assign w_wr_en = put_valid && put_ready && !flush && !w_pass;
  assign w_rd_en = get_valid && get_ready && !w_empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_wr_en) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
      if (w_rd_en) rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   count_d = count_q + c_cnt_w'(1);
        2'b01:   count_d = count_q - c_cnt_w'(1);
        default: count_d = count_q;
      endcase
    end
    max_d = (count_d > max_q) ? count_d : max_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      max_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) mem_q[wr_ptr_q[c_aw-1:0]] <= put_data;
  end

  assign count        = count_q;
  assign max_level    = max_q;
  assign almost_full  = (count_q >= c_af);
  assign almost_empty = (count_q <= c_ae);

endmodule
`default_nettype wire
